audio_burst_reader: RTL and testbench

AUDIO_BURST_READER -- requirements
Module: audio_burst_reader

---
 rtl/audio_burst_reader.sv | 268 ++++++++++++++++++++++++++
 tb/tb_audio_burst_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_burst_reader.sv
// Audio burst reader: fetches a clip from word-addressed memory with
// Avalon-MM read bursts, buffers frames in a small FIFO and hands one
// frame to the consumer per sample_tick. Supports one-shot, looped and
// aborted playback.
module audio_burst_reader #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int BC_W       = 4,
    parameter int BURST_MAX  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [BC_W-1:0]   avm_burstcount,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic              sample_tick,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    localparam logic [ADDR_W-1:0] BURST_MAX_A = ADDR_W'(BURST_MAX);
    localparam logic [BC_W-1:0]   BURST_MAX_B = BC_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [BC_W-1:0]   ONE_B       = BC_W'(1);

    // Control state
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              loop_q, loop_d;
    logic [BC_W-1:0]   beats_q, beats_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   bc_q, bc_d;

    // Frame FIFO and output stage
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic              svalid_q, svalid_d;
    logic              under_q, under_d;

    logic              push, pop, flush, accept;
    logic [BC_W-1:0]   blen;
    logic [CNT_W-1:0]  free;

    // Playback FSM: burst requests, beat accounting, loop reload and abort
    always_comb begin
        // NOTE: every variable assigned here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        base_d      = base_q;
        len_d       = len_q;
        loop_d      = loop_q;
        beats_d     = beats_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_d        = rd_q;
        addr_d      = addr_q;
        bc_d        = bc_q;
        push        = 1'b0;
        flush       = 1'b0;
        free        = DEPTH_C - count_q;
        blen        = (remaining_q >= BURST_MAX_A) ? BURST_MAX_B : remaining_q[BC_W-1:0];
        accept      = rd_q && !avm_waitrequest;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        base_d      = base_addr;
                        len_d       = length;
                        loop_d      = loop_en;
                        cur_addr_d  = base_addr;
                        remaining_d = length;
                        busy_d      = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (accept) begin
                    // A stop in the acceptance cycle is too late: the burst is owed.
                    rd_d        = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_W'(bc_q);
                    remaining_d = remaining_q - ADDR_W'(bc_q);
                    beats_d     = bc_q;
                    state_d     = stop ? S_ABORT : S_DATA;
                end else if (stop) begin
                    rd_d    = 1'b0;
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!rd_q && free >= CNT_W'(blen)) begin
                    // Only ask for a burst the FIFO can swallow whole.
                    rd_d   = 1'b1;
                    addr_d = cur_addr_q;
                    bc_d   = blen;
                end
            end
            S_DATA: begin
                if (avm_readdatavalid) begin
                    push    = 1'b1;
                    beats_d = beats_q - ONE_B;
                    if (beats_q == ONE_B) begin
                        if (stop) begin
                            flush   = 1'b1;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else if (remaining_q != '0) begin
                            state_d = S_REQ;
                        end else if (loop_q) begin
                            cur_addr_d  = base_q;
                            remaining_d = len_q;
                            state_d     = S_REQ;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (stop) begin
                        state_d = S_ABORT;
                    end
                end else if (stop) begin
                    state_d = S_ABORT;
                end
            end
            S_DRAIN: begin
                if (stop || count_q == '0) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                // Beats still owed by the slave are counted but never stored.
                if (avm_readdatavalid && beats_q != '0) begin
                    beats_d = beats_q - ONE_B;
                end
                if (beats_q == '0 || (avm_readdatavalid && beats_q == ONE_B)) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and consumer side; a tick on an empty FIFO never bypasses
    always_comb begin
        pop      = sample_tick && busy_q && (count_q != '0);
        under_d  = sample_tick && busy_q && (count_q == '0);
        svalid_d = pop;
        sdata_d  = pop ? mem_q[rd_ptr_q] : sdata_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage
    // NOTE: the frame array has no reset; emptiness is defined by the
    // pointers and count alone, which keeps the storage plain RAM.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= avm_readdata;
        end
    end

    // State registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            base_q      <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            beats_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            bc_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sdata_q     <= '0;
            svalid_q    <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            base_q      <= base_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            beats_q     <= beats_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            bc_q        <= bc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sdata_q     <= sdata_d;
            svalid_q    <= svalid_d;
            under_q     <= under_d;
        end
    end

    // A write into a full FIFO means the free-space check before a burst is broken.
    a_no_overflow: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
        !(push && count_q == DEPTH_C));

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_read       = rd_q;
    assign avm_address    = addr_q;
    assign avm_burstcount = bc_q;
    assign sample_data    = sdata_q;
    assign sample_valid   = svalid_q;
    assign underrun       = under_q;

endmodule

// File: tb/tb_audio_burst_reader.sv
// Directed bench for audio_burst_reader: a behavioural Avalon slave and
// tick generator run on the falling edge; the directed sequence samples
// DUT outputs 1 ns after each rising edge.
module tb_audio_burst_reader;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        start, stop, loop_en;
    logic [17:0] base_addr, length;
    logic        busy, done;
    logic [17:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest, avm_readdatavalid;
    logic        sample_tick;
    logic [31:0] sample_data;
    logic        sample_valid, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave / tick generator / monitor state
    int          sl_beats = 0, sl_delay = 0, sl_sent = 0, sl_stall = 0, sl_lat = 0;
    logic [17:0] sl_addr = '0;
    int          tick_per = 0, tick_div = 0, man_ticks = 0;
    logic [31:0] got [$];
    logic [17:0] acc_addr [$];
    logic [3:0]  acc_bc [$];
    int          uf_cnt = 0, done_cnt = 0;

    audio_burst_reader dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .start             (start),
        .stop              (stop),
        .loop_en           (loop_en),
        .base_addr         (base_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .sample_tick       (sample_tick),
        .sample_data       (sample_data),
        .sample_valid      (sample_valid),
        .underrun          (underrun)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    function automatic logic [31:0] frame_of(input logic [17:0] a);
        return {8'hA5, 6'd0, a};
    endfunction

    // Memory slave, tick source and output monitor, all on the falling edge
    always @(negedge clk_clk) begin
        avm_readdatavalid = 1'b0;
        sample_tick       = 1'b0;
        if (sl_beats != 0) begin
            if (sl_delay != 0) begin
                sl_delay--;
            end else begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = frame_of(sl_addr);
                sl_addr++;
                sl_beats--;
                sl_sent++;
            end
        end
        avm_waitrequest = 1'b0;
        if (avm_read === 1'b1 && sl_beats == 0) begin
            if (sl_stall != 0) begin
                avm_waitrequest = 1'b1;
                sl_stall--;
            end else begin
                acc_addr.push_back(avm_address);
                acc_bc.push_back(avm_burstcount);
                sl_addr  = avm_address;
                sl_beats = int'(avm_burstcount);
                sl_delay = sl_lat;
                sl_sent  = 0;
            end
        end
        if (man_ticks != 0) begin
            sample_tick = 1'b1;
            man_ticks--;
        end else if (tick_per != 0) begin
            if (tick_div == 0) begin
                sample_tick = 1'b1;
                tick_div    = tick_per - 1;
            end else begin
                tick_div--;
            end
        end
        if (sample_valid === 1'b1) got.push_back(sample_data);
        if (underrun === 1'b1) uf_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        got.delete();
        acc_addr.delete();
        acc_bc.delete();
        uf_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [17:0] b, input logic [17:0] len, input logic lp);
        base_addr = b;
        length    = len;
        loop_en   = lp;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) step(1);
        check(tag, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_frames(input string tag, input logic [17:0] base, input int n);
        check({tag, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [17:0] a;
            logic [31:0] v;
            a = base + 18'(i);
            v = (i < got.size()) ? got[i] : 32'hFFFF_FFFF;
            check(tag, 64'(v), 64'(frame_of(a)));
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        base_addr = '0; length = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        sample_tick = 1'b0;

        // Reset values
        step(3);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(done), 64'd0);
        check("rst_read",   64'(avm_read), 64'd0);
        check("rst_valid",  64'(sample_valid), 64'd0);
        check("rst_under",  64'(underrun), 64'd0);
        check("rst_addr",   64'(avm_address), 64'd0);
        check("rst_bc",     64'(avm_burstcount), 64'd0);
        check("rst_sdata",  64'(sample_data), 64'd0);
        reset_reset_n = 1'b1;
        step(2);

        // Tick while idle is ignored
        clear_sb();
        man_ticks = 1;
        step(3);
        check("idle_tick_under", 64'(uf_cnt), 64'd0);
        check("idle_tick_valid", 64'(got.size()), 64'd0);

        // One-shot 20 words from 0x100, ticks every 4 cycles
        clear_sb();
        tick_div = 8; tick_per = 4;
        pulse_start(18'h100, 18'd20, 1'b0);
        check("os_busy", 64'(busy), 64'd1);
        wait_done("os_done", 250);
        tick_per = 0;
        check("os_busy_end", 64'(busy), 64'd0);
        check("os_nbursts", 64'(acc_addr.size()), 64'd3);
        check("os_addr0", 64'(acc_addr[0]), 64'h100);
        check("os_bc0",   64'(acc_bc[0]), 64'd8);
        check("os_addr1", 64'(acc_addr[1]), 64'h108);
        check("os_bc1",   64'(acc_bc[1]), 64'd8);
        check("os_addr2", 64'(acc_addr[2]), 64'h110);
        check("os_bc2",   64'(acc_bc[2]), 64'd4);
        check_frames("os_frame", 18'h100, 20);
        check("os_under", 64'(uf_cnt), 64'd0);

        // Waitrequest stall of 5 cycles on the first burst
        step(3);
        clear_sb();
        sl_stall = 5;
        pulse_start(18'h200, 18'd8, 1'b0);
        for (int i = 0; i < 20 && avm_read !== 1'b1; i++) step(1);
        check("st_read_rise", 64'(avm_read), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("st_read_hold", 64'(avm_read), 64'd1);
            check("st_addr_hold", 64'(avm_address), 64'h200);
            check("st_bc_hold",   64'(avm_burstcount), 64'd8);
        end
        step(1);
        check("st_read_drop", 64'(avm_read), 64'd0);
        check("st_accepted", 64'(acc_addr.size()), 64'd1);
        tick_div = 0; tick_per = 4;
        wait_done("st_done", 100);
        tick_per = 0;
        check_frames("st_frame", 18'h200, 8);

        // Looped 3-word clip, 9 ticks, then stop
        step(3);
        clear_sb();
        tick_div = 8; tick_per = 4;
        pulse_start(18'h300, 18'd3, 1'b1);
        for (int i = 0; i < 150 && got.size() < 9; i++) step(1);
        tick_per = 0;
        step(2);
        check("lp_count", 64'(got.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            logic [17:0] a;
            logic [31:0] v;
            a = 18'h300 + 18'(i % 3);
            v = (i < got.size()) ? got[i] : 32'hFFFF_FFFF;
            check("lp_frame", 64'(v), 64'(frame_of(a)));
        end
        check("lp_busy", 64'(busy), 64'd1);
        check("lp_no_done", 64'(done_cnt), 64'd0);
        pulse_stop();
        wait_done("lp_done", 60);
        check("lp_busy_end", 64'(busy), 64'd0);
        check("lp_under", 64'(uf_cnt), 64'd0);

        // Backpressure: no ticks, 16 words fill the FIFO
        step(5);
        clear_sb();
        pulse_start(18'h400, 18'd64, 1'b0);
        step(60);
        check("bp_nbursts", 64'(acc_addr.size()), 64'd2);
        check("bp_read_idle", 64'(avm_read), 64'd0);
        for (int k = 0; k < 7; k++) begin
            man_ticks = 1;
            step(3);
            check("bp_hold", 64'(avm_read), 64'd0);
        end
        check("bp_nbursts_hold", 64'(acc_addr.size()), 64'd2);
        man_ticks = 1;
        step(5);
        check("bp_nbursts_resume", 64'(acc_addr.size()), 64'd3);
        check("bp_addr_resume", 64'(acc_addr[2]), 64'h410);
        check_frames("bp_frame", 18'h400, 8);
        pulse_stop();
        wait_done("bp_done", 60);
        check("bp_busy_end", 64'(busy), 64'd0);

        // Underrun: slow slave, tick two cycles after start
        step(3);
        clear_sb();
        sl_lat = 20;
        pulse_start(18'h500, 18'd4, 1'b0);
        step(1);
        man_ticks = 1;
        step(3);
        check("ur_pulse", 64'(uf_cnt), 64'd1);
        check("ur_no_valid", 64'(got.size()), 64'd0);
        step(40);
        tick_div = 0; tick_per = 4;
        wait_done("ur_done", 60);
        tick_per = 0;
        sl_lat = 0;
        check_frames("ur_frame", 18'h500, 4);
        check("ur_once", 64'(uf_cnt), 64'd1);

        // Stop while the request is still stalled
        step(3);
        clear_sb();
        sl_stall = 3;
        pulse_start(18'h680, 18'd8, 1'b0);
        for (int i = 0; i < 20 && avm_read !== 1'b1; i++) step(1);
        pulse_stop();
        sl_stall = 0;
        check("rs_read_drop", 64'(avm_read), 64'd0);
        check("rs_done", 64'(done), 64'd1);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_no_accept", 64'(acc_addr.size()), 64'd0);

        // Abort during the third beat of eight
        step(3);
        clear_sb();
        pulse_start(18'h600, 18'd8, 1'b0);
        for (int i = 0; i < 30 && !(acc_addr.size() == 1 && sl_sent == 2); i++) step(1);
        pulse_stop();
        wait_done("ab_done", 40);
        check("ab_beats_absorbed", 64'(sl_beats), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_no_frames", 64'(got.size()), 64'd0);

        // Address wrap; the first frames also prove the abort flushed the FIFO
        step(3);
        clear_sb();
        tick_div = 8; tick_per = 4;
        pulse_start(18'h3FFFE, 18'd12, 1'b0);
        wait_done("wr_done", 150);
        tick_per = 0;
        check("wr_nbursts", 64'(acc_addr.size()), 64'd2);
        check("wr_addr0", 64'(acc_addr[0]), 64'h3FFFE);
        check("wr_addr1", 64'(acc_addr[1]), 64'h00006);
        check("wr_bc1",   64'(acc_bc[1]), 64'd4);
        check_frames("wr_frame", 18'h3FFFE, 12);

        // Zero length: done only
        step(3);
        clear_sb();
        pulse_start(18'h900, 18'd0, 1'b0);
        check("zl_done", 64'(done), 64'd1);
        check("zl_busy", 64'(busy), 64'd0);
        step(5);
        check("zl_no_read", 64'(acc_addr.size()), 64'd0);
        check("zl_done_once", 64'(done_cnt), 64'd1);

        // Start while busy is ignored
        step(3);
        clear_sb();
        tick_div = 8; tick_per = 4;
        pulse_start(18'hA00, 18'd4, 1'b0);
        step(2);
        pulse_start(18'hB00, 18'd8, 1'b0);
        wait_done("sb_done", 100);
        tick_per = 0;
        check("sb_nbursts", 64'(acc_addr.size()), 64'd1);
        check_frames("sb_frame", 18'hA00, 4);

        // Reset mid-burst, late beats ignored, clean restart
        step(3);
        clear_sb();
        pulse_start(18'h700, 18'd8, 1'b0);
        for (int i = 0; i < 30 && !(acc_addr.size() == 1 && sl_sent == 2); i++) step(1);
        reset_reset_n = 1'b0;
        #1;
        check("mr_busy",  64'(busy), 64'd0);
        check("mr_read",  64'(avm_read), 64'd0);
        check("mr_addr",  64'(avm_address), 64'd0);
        check("mr_sdata", 64'(sample_data), 64'd0);
        step(2);
        reset_reset_n = 1'b1;
        for (int i = 0; i < 30 && sl_beats != 0; i++) step(1);
        step(2);
        clear_sb();
        tick_div = 8; tick_per = 4;
        pulse_start(18'h800, 18'd4, 1'b0);
        wait_done("mr_done", 100);
        tick_per = 0;
        check_frames("mr_frame", 18'h800, 4);
        check("mr_under", 64'(uf_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
